// File: rtl/pipe_mem_wb.sv
// rtl/pipe_mem_wb.sv - MEM/WB pipeline register
// Registers MEM-stage results for WB; synchronous reset inserts a bubble.
module pipe_mem_wb #(
  parameter int N = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] ReadData_i,
  input  logic [N-1:0] AluResult_i,
  input  logic [3:0]   A3_i,
  input  logic         RF_WE_i,
  input  logic         MemWE_i,
  input  logic         WBSelect_i,
  output logic [N-1:0] ReadData_o,
  output logic [N-1:0] AluResult_o,
  output logic [3:0]   A3_o,
  output logic         RF_WE_o,
  output logic         MemWE_o,
  output logic         WBSelect_o
);

  // A cleared stage must not write the register file or memory.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ReadData_o  <= '0;
      AluResult_o <= '0;
      A3_o        <= 4'b0000;
      RF_WE_o     <= 1'b0;
      MemWE_o     <= 1'b0;
      WBSelect_o  <= 1'b0;
    end else begin
      ReadData_o  <= ReadData_i;
      AluResult_o <= AluResult_i;
      A3_o        <= A3_i;
      RF_WE_o     <= RF_WE_i;
      MemWE_o     <= MemWE_i;
      WBSelect_o  <= WBSelect_i;
    end
  end

endmodule

// File: tb/tb_pipe_mem_wb.sv
// tb/tb_pipe_mem_wb.sv - directed self-checking bench for pipe_mem_wb
module tb_pipe_mem_wb;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] ReadData_i, AluResult_i;
  logic [3:0]  A3_i;
  logic        RF_WE_i, MemWE_i, WBSelect_i;
  logic [31:0] ReadData_o, AluResult_o;
  logic [3:0]  A3_o;
  logic        RF_WE_o, MemWE_o, WBSelect_o;

  int checkCount = 0;
  int passCount  = 0;

  always #5 CLK = ~CLK;

  pipe_mem_wb #(.N(32)) dut (
    .CLK(CLK), .RST(RST),
    .ReadData_i(ReadData_i), .AluResult_i(AluResult_i), .A3_i(A3_i),
    .RF_WE_i(RF_WE_i), .MemWE_i(MemWE_i), .WBSelect_i(WBSelect_i),
    .ReadData_o(ReadData_o), .AluResult_o(AluResult_o), .A3_o(A3_o),
    .RF_WE_o(RF_WE_o), .MemWE_o(MemWE_o), .WBSelect_o(WBSelect_o)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic stepEdge();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [31:0] rd, input logic [31:0] alu,
                          input logic [3:0] a3, input logic [2:0] ctl);
    checkVal({tag, ".ReadData"},  ReadData_o,  rd);
    checkVal({tag, ".AluResult"}, AluResult_o, alu);
    checkVal({tag, ".A3"},        {28'd0, A3_o}, {28'd0, a3});
    checkVal({tag, ".ctl"},       {29'd0, RF_WE_o, MemWE_o, WBSelect_o}, {29'd0, ctl});
  endtask

  initial begin
    logic [3:0] streamVals [4];
    streamVals = '{4'd1, 4'd2, 4'd3, 4'd4};

    ReadData_i = 32'h7894ACD0; AluResult_i = 32'h00000002; A3_i = 4'b0011;
    RF_WE_i = 1'b1; MemWE_i = 1'b1; WBSelect_i = 1'b1;
    RST = 1'b1;
    stepEdge();
    checkAll("reset", 32'h0, 32'h0, 4'h0, 3'b000);

    RST = 1'b0;
    stepEdge();
    checkAll("capture", 32'h7894ACD0, 32'h00000002, 4'b0011, 3'b111);

    // Mid-cycle change must not reach the output before the next edge.
    #4;
    AluResult_i = 32'hFFFFFFFF;
    #2;
    checkVal("hold.AluResult", AluResult_o, 32'h00000002);
    RST = 1'b1;
    #1;
    RST = 1'b0;
    checkVal("hold.rstGlitch", AluResult_o, 32'h00000002);
    stepEdge();
    checkVal("latency.AluResult", AluResult_o, 32'hFFFFFFFF);

    foreach (streamVals[i]) begin
      A3_i = streamVals[i];
      stepEdge();
      checkVal($sformatf("stream.A3[%0d]", i), {28'd0, A3_o}, {28'd0, streamVals[i]});
    end

    ReadData_i = 32'hDEADBEEF;
    RST = 1'b1;
    stepEdge();
    checkAll("midReset", 32'h0, 32'h0, 4'h0, 3'b000);
    RST = 1'b0;
    ReadData_i = 32'h12345678;
    stepEdge();
    checkVal("afterReset.ReadData", ReadData_o, 32'h12345678);
    checkVal("afterReset.A3", {28'd0, A3_o}, 32'd4);

    RF_WE_i = 1'b1; MemWE_i = 1'b0; WBSelect_i = 1'b1;
    stepEdge();
    checkVal("ctl.pat101", {29'd0, RF_WE_o, MemWE_o, WBSelect_o}, 32'b101);
    RF_WE_i = 1'b0; MemWE_i = 1'b1; WBSelect_i = 1'b0;
    stepEdge();
    checkVal("ctl.pat010", {29'd0, RF_WE_o, MemWE_o, WBSelect_o}, 32'b010);

    // Full-width bit-exactness on alternating patterns.
    ReadData_i = 32'hA5A5A5A5; AluResult_i = 32'h5A5A5A5A; A3_i = 4'hF;
    stepEdge();
    checkAll("width", 32'hA5A5A5A5, 32'h5A5A5A5A, 4'hF, 3'b010);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
